// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick burst scheduler.
//   - sched_state_e : scheduler FSM states
//   - Def*          : default parameter values
//   - rr_pick       : round-robin pick, first set request after 'last' with wrap
package tick_sched_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } sched_state_e;

    localparam int unsigned DefNumReq = 4;
    localparam int unsigned DefCntW   = 32;
    localparam int unsigned DefBurstW = 16;
    localparam int unsigned MaxReq    = 16;

    // Searches (last+1) mod n upward with wrap; returns 0 when nothing is set
    // (the caller only uses the result when some request is pending).
    function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                            input int unsigned       last,
                                            input int unsigned       n);
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = 0;
        found = 1'b0;
        for (int unsigned i = 1; i <= MaxReq; i++) begin
            idx = last + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (i <= n) && req[idx[3:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tick_sched_divider.sv
// Programmable tick divider shared by all requesters.
// Counts 0..i_DIV while enabled and flags o_TICK when the count equals i_DIV,
// giving a period of i_DIV+1 cycles. The compare happens before the increment,
// so i_DIV = all-ones wraps cleanly without overflow.
// Ports:
//   i_CLK, i_RST : clock, synchronous active-high reset
//   i_CLR        : clear counter to 0 (takes priority over i_EN)
//   i_EN         : count enable
//   i_DIV        : divide value
//   o_TICK       : high for the cycle in which count == i_DIV (while enabled)
module tick_sched_divider #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_CLR,
    input  logic             i_EN,
    input  logic [CNT_W-1:0] i_DIV,
    output logic             o_TICK
);

    logic [CNT_W-1:0] count_q;
    logic             at_top;

    assign at_top = (count_q == i_DIV);
    assign o_TICK = i_EN && at_top;

    always_ff @(posedge i_CLK) begin
        if (i_RST || i_CLR) begin
            count_q <= '0;
        end else if (i_EN) begin
            count_q <= at_top ? '0 : count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tick_burst_scheduler.sv
// Round-robin scheduler sharing one tick divider among NUM_REQ requesters.
// A granted requester gets exactly its BURST_LEN ticks at its own divide value,
// tagged with its index, followed by a one-cycle o_DONE pulse.
// Optional feature macro: TICK_SCHED_ABORT_EN -- when defined, dropping the
// owner's request during RUN ends the burst early.
// Ports:
//   i_CLK, i_RST : clock, synchronous active-high reset
//   i_REQ        : per-requester burst request level
//   i_DIV_VALUE  : per-requester divide value, slice k = [k*CNT_W +: CNT_W]
//   i_BURST_LEN  : per-requester tick count, slice k = [k*BURST_W +: BURST_W]
//   o_GRANT      : one-hot owner, high in LOAD and RUN
//   o_TICK       : one-cycle tick pulse
//   o_TICK_ID    : owner index while o_TICK is high, else 0
//   o_DONE       : one-cycle completion pulse for the owner
//   o_BUSY       : high in every state except IDLE
module tick_burst_scheduler
    import tick_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned CNT_W   = DefCntW,
    parameter int unsigned BURST_W = DefBurstW
) (
    input  logic                       i_CLK,
    input  logic                       i_RST,
    input  logic [NUM_REQ-1:0]         i_REQ,
    input  logic [NUM_REQ*CNT_W-1:0]   i_DIV_VALUE,
    input  logic [NUM_REQ*BURST_W-1:0] i_BURST_LEN,
    output logic [NUM_REQ-1:0]         o_GRANT,
    output logic                       o_TICK,
    output logic [$clog2(NUM_REQ)-1:0] o_TICK_ID,
    output logic [NUM_REQ-1:0]         o_DONE,
    output logic                       o_BUSY
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    sched_state_e     state_q;
    logic [IdW-1:0]   owner_q;
    logic [IdW-1:0]   last_q;
    logic [CNT_W-1:0] div_q;
    logic [BURST_W-1:0] remaining_q;
    logic [NUM_REQ-1:0] grant_q;
    logic             tick_q;
    logic [IdW-1:0]   tick_id_q;
    logic [NUM_REQ-1:0] done_q;
    logic             busy_q;

    logic [MaxReq-1:0]  req_pad;
    logic [IdW-1:0]     pick_idx;
    logic [CNT_W-1:0]   pick_div;
    logic [BURST_W-1:0] pick_len;
    logic               div_en;
    logic               div_clr;
    logic               div_tick;
    logic               abort;

    always_comb begin
        req_pad = '0;
        req_pad[NUM_REQ-1:0] = i_REQ;
        pick_idx = IdW'(rr_pick(req_pad, 32'(last_q), NUM_REQ));
        pick_div = '0;
        pick_len = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IdW'(k)) begin
                pick_div = i_DIV_VALUE[k*CNT_W +: CNT_W];
                pick_len = i_BURST_LEN[k*BURST_W +: BURST_W];
            end
        end
    end

`ifdef TICK_SCHED_ABORT_EN
    assign abort = ~i_REQ[owner_q];
`else
    assign abort = 1'b0;
`endif

    // The cycle after the final tick is spent in RUN with remaining == 0;
    // gating the enable there stops a DIV=0 burst from ticking once too often.
    assign div_en  = (state_q == StRun) && (remaining_q != '0);
    assign div_clr = (state_q == StLoad);

    tick_sched_divider #(
        .CNT_W(CNT_W)
    ) u_divider (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .i_CLR (div_clr),
        .i_EN  (div_en),
        .i_DIV (div_q),
        .o_TICK(div_tick)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            last_q      <= IdW'(NUM_REQ - 1);
            div_q       <= '0;
            remaining_q <= '0;
            grant_q     <= '0;
            tick_q      <= 1'b0;
            tick_id_q   <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            tick_q    <= 1'b0;
            tick_id_q <= '0;
            done_q    <= '0;
            case (state_q)
                StIdle: begin
                    if (|i_REQ) begin
                        owner_q           <= pick_idx;
                        div_q             <= pick_div;
                        remaining_q       <= pick_len;
                        grant_q           <= '0;
                        grant_q[pick_idx] <= 1'b1;
                        busy_q            <= 1'b1;
                        state_q           <= StLoad;
                    end
                end
                StLoad: begin
                    if (remaining_q == '0) begin
                        grant_q          <= '0;
                        done_q[owner_q]  <= 1'b1;
                        state_q          <= StDone;
                    end else begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (div_tick) begin
                        tick_q      <= 1'b1;
                        tick_id_q   <= owner_q;
                        remaining_q <= remaining_q - BURST_W'(1);
                    end
                    if ((remaining_q == '0) || abort) begin
                        grant_q         <= '0;
                        done_q[owner_q] <= 1'b1;
                        state_q         <= StDone;
                    end
                end
                StDone: begin
                    last_q  <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_GRANT   = grant_q;
    assign o_TICK    = tick_q;
    assign o_TICK_ID = tick_id_q;
    assign o_DONE    = done_q;
    assign o_BUSY    = busy_q;

endmodule
